alu_issue_ctrl: RTL and testbench

Initiator side of the ALU interface. It accepts decoded execute requests through a valid/ready handshake and drives the combinational ALU's operand1, operand2, operation and flags_in. It captures the ALU's result and carry, maintains the condition-code register (CCR), and presents results to writeback through a second valid/ready handshake. It sits between the decode/register-read stage and writeback.

---
 rtl/alu_issue_ctrl_pkg.sv | 23 ++
 rtl/alu_issue_ctrl_ccr_update.sv | 48 ++++
 rtl/alu_issue_ctrl.sv | 113 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, CCR bit
// positions and default widths.
package alu_issue_ctrl_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_REG_AW = 3;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SETC  = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_NOT   = 3'b100,
        OP_PASSA = 3'b101,
        OP_PASSB = 3'b110,
        OP_NONE  = 3'b111
    } alu_op_e;

    localparam int CCR_C = 0;
    localparam int CCR_Z = 1;
    localparam int CCR_N = 2;

endpackage

// File: rtl/alu_issue_ctrl_ccr_update.sv
// Next condition-code value for the instruction being captured from the ALU.
// sub_carry is the carry value a subtract writes (borrow, or the old C).
module alu_issue_ctrl_ccr_update
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] result,
    input  logic              carry,
    input  logic              sub_carry,
    input  logic [2:0]        ccr_in,
    output logic [2:0]        ccr_out
);

    logic zero;
    logic neg;

    assign zero = (result == '0);
    assign neg  = result[DATA_W-1];

    always_comb begin
        ccr_out = ccr_in;
        case (op)
            OP_ADD: begin
                ccr_out[CCR_C] = carry;
                ccr_out[CCR_Z] = zero;
                ccr_out[CCR_N] = neg;
            end
            OP_SETC: begin
                ccr_out[CCR_C] = 1'b1;
            end
            OP_SUB: begin
                ccr_out[CCR_C] = sub_carry;
                ccr_out[CCR_Z] = zero;
                ccr_out[CCR_N] = neg;
            end
            OP_AND, OP_NOT: begin
                ccr_out[CCR_Z] = zero;
                ccr_out[CCR_N] = neg;
            end
            default: begin
                ccr_out = ccr_in;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU initiator: ISSUE register drives the ALU, RESULT register feeds writeback.
// Define ALU_SUB_BORROW_EN to have subtract write the unsigned borrow into C.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [REG_AW-1:0] req_rdst,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [2:0]        alu_operation,
    output logic [2:0]        alu_flags_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_rdst,
    output logic              wb_we,
    output logic [2:0]        ccr,
    output logic              illegal_op
);

    logic              iss_valid;
    alu_op_e           iss_op;
    logic [DATA_W-1:0] iss_a;
    logic [DATA_W-1:0] iss_b;
    logic [REG_AW-1:0] iss_rdst;

    logic       advance;
    logic       accept;
    logic       no_write;
    logic       sub_carry;
    logic [2:0] ccr_nxt;

    assign advance   = iss_valid & (~wb_valid | wb_ready);
    assign req_ready = ~iss_valid | advance;
    assign accept    = req_valid & req_ready;
    assign no_write  = (iss_op == OP_SETC) | (iss_op == OP_NONE);

    assign alu_operand1  = iss_a;
    assign alu_operand2  = iss_b;
    assign alu_operation = iss_valid ? iss_op : OP_NONE;
    assign alu_flags_in  = ccr;

`ifdef ALU_SUB_BORROW_EN
    assign sub_carry = (iss_a < iss_b);
`else
    assign sub_carry = ccr[CCR_C];
`endif

    alu_issue_ctrl_ccr_update #(
        .DATA_W (DATA_W)
    ) u_ccr_update (
        .op        (iss_op),
        .result    (alu_result),
        .carry     (alu_carry),
        .sub_carry (sub_carry),
        .ccr_in    (ccr),
        .ccr_out   (ccr_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_op    <= OP_NONE;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_rdst  <= '0;
        end else if (accept) begin
            iss_valid <= 1'b1;
            iss_op    <= alu_op_e'(req_op);
            iss_a     <= req_a;
            iss_b     <= req_b;
            iss_rdst  <= req_rdst;
        end else if (advance) begin
            iss_valid <= 1'b0;
        end
    end

    // Illegal ops and setc still produce a beat, but never a register write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rdst    <= '0;
            wb_we      <= 1'b0;
            ccr        <= 3'b000;
            illegal_op <= 1'b0;
        end else if (advance) begin
            wb_valid   <= 1'b1;
            wb_data    <= no_write ? '0 : alu_result;
            wb_rdst    <= iss_rdst;
            wb_we      <= ~no_write;
            ccr        <= ccr_nxt;
            illegal_op <= (iss_op == OP_NONE);
        end else begin
            if (wb_ready) begin
                wb_valid <= 1'b0;
            end
            illegal_op <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and flag model.
module tb_alu_issue_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic [AW-1:0] req_rdst;
    logic [DW-1:0] alu_operand1;
    logic [DW-1:0] alu_operand2;
    logic [2:0]    alu_operation;
    logic [2:0]    alu_flags_in;
    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_rdst;
    logic          wb_we;
    logic [2:0]    ccr;
    logic          illegal_op;

    alu_issue_ctrl #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_rdst      (req_rdst),
        .alu_operand1  (alu_operand1),
        .alu_operand2  (alu_operand2),
        .alu_operation (alu_operation),
        .alu_flags_in  (alu_flags_in),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_rdst       (wb_rdst),
        .wb_we         (wb_we),
        .ccr           (ccr),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    // Combinational ALU stand-in
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_operation)
            3'd0: {alu_carry, alu_result} = {1'b0, alu_operand1} + {1'b0, alu_operand2};
            3'd2: alu_result = alu_operand1 - alu_operand2;
            3'd3: alu_result = alu_operand1 & alu_operand2;
            3'd4: alu_result = ~alu_operand1;
            3'd5: alu_result = alu_operand1;
            3'd6: alu_result = alu_operand2;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] rdst;
        logic          we;
        logic [2:0]    ccr;
        logic          ill;
        logic          chk_data;
        int            acc;
    } exp_t;

    exp_t       sbq[$];
    exp_t       cur;
    logic [2:0] m_ccr;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    bit         no_bp;
    bit         rand_bp;
    bit         pv;
    bit         px;
    bit         cur_ok;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference model: effect of one instruction, in program order
    function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [AW-1:0] rd);
        exp_t e;
        logic [DW:0] s;
        logic [DW-1:0] d;
        bit zn;
        e.rdst = rd;
        e.ill = (op == 3'd7);
        e.we = !(op == 3'd1 || op == 3'd7);
        e.chk_data = (op != 3'd1);
        e.acc = 0;
        d = '0;
        zn = 0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                d = s[DW-1:0];
                m_ccr[0] = s[DW];
                zn = 1;
            end
            3'd1: m_ccr[0] = 1'b1;
            3'd2: begin
                d = a - b;
                zn = 1;
`ifdef ALU_SUB_BORROW_EN
                m_ccr[0] = (a < b);
`endif
            end
            3'd3: begin d = a & b; zn = 1; end
            3'd4: begin d = ~a; zn = 1; end
            3'd5: d = a;
            3'd6: d = b;
            default: d = '0;
        endcase
        if (zn) begin
            m_ccr[1] = (d == 0);
            m_ccr[2] = d[DW-1];
        end
        e.data = d;
        e.ccr = m_ccr;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) wb_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send(input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] rd);
        exp_t e;
        bit done;
        done = 0;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_rdst = rd;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (req_ready) begin
                e = model(op, a, b, rd);
                e.acc = cyc;
                sbq.push_back(e);
                done = 1;
            end
            tick();
        end
        if (!done) chk("accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        tick();
        tick();
        sbq.delete();
        m_ccr = 3'b000;
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_wb_data", int'(wb_data), 0);
        chk("rst_wb_rdst", int'(wb_rdst), 0);
        chk("rst_wb_we", int'(wb_we), 0);
        chk("rst_ccr", int'(ccr), 0);
        chk("rst_illegal", int'(illegal_op), 0);
        chk("rst_alu_op", int'(alu_operation), 7);
        chk("rst_operand1", int'(alu_operand1), 0);
        chk("rst_operand2", int'(alu_operand2), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        rst_n = 1'b1;
    endtask

    // Monitor: a fresh beat pops the scoreboard; a held beat must not move
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 0;
            px = 0;
            cur_ok = 0;
        end else begin
            if (wb_valid) begin
                if (!pv || px) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                        cur_ok = 0;
                    end else begin
                        cur = sbq.pop_front();
                        cur_ok = 1;
                        chk("latency_ok", int'(no_bp ? (cyc - cur.acc == 2) : (cyc - cur.acc >= 2)), 1);
                        chk("illegal_pulse", int'(illegal_op), int'(cur.ill));
                    end
                end else begin
                    chk("illegal_once", int'(illegal_op), 0);
                end
                if (cur_ok) begin
                    if (cur.chk_data) chk("wb_data", int'(wb_data), int'(cur.data));
                    chk("wb_rdst", int'(wb_rdst), int'(cur.rdst));
                    chk("wb_we", int'(wb_we), int'(cur.we));
                    chk("ccr", int'(ccr), int'(cur.ccr));
                end
            end else begin
                chk("illegal_idle", int'(illegal_op), 0);
            end
            pv = wb_valid;
            px = wb_valid && wb_ready;
        end
    end

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        req_rdst = '0;
        wb_ready = 1'b1;
        m_ccr = 3'b000;
        no_bp = 1;
        rand_bp = 0;
        tick();
        do_reset();

        // Add with carry-out and zero result
        send(3'd0, 16'hFFFF, 16'h0001, 3'd2);
        repeat (4) tick();
        chk("add_ccr", int'(ccr), 3'b011);

        // setc then pass-A back-to-back: C visible in pass-A's issue cycle
        do_reset();
        send(3'd1, 16'h0000, 16'h0000, 3'd1);
        send(3'd5, 16'h8000, 16'h0000, 3'd4);
        chk("passa_issue_op", int'(alu_operation), 5);
        chk("passa_flags_in_c", int'(alu_flags_in[0]), 1);
        repeat (4) tick();
        chk("setc_pass_ccr", int'(ccr), 3'b001);

        // not under writeback backpressure
        do_reset();
        no_bp = 0;
        wb_ready = 1'b0;
        send(3'd4, 16'h00FF, 16'h0000, 3'd1);
        send(3'd6, 16'h0000, 16'h1234, 3'd3);
        chk("stall_req_ready", int'(req_ready), 0);
        chk("stall_ccr", int'(ccr), 3'b100);
        repeat (3) tick();
        chk("stall_hold_data", int'(wb_data), 16'hFF00);
        wb_ready = 1'b1;
        repeat (4) tick();

        // Illegal op and subtract
        no_bp = 1;
        send(3'd7, 16'h1111, 16'h2222, 3'd5);
        repeat (3) tick();
        chk("illegal_ccr_kept", int'(ccr), 3'b100);
        send(3'd2, 16'h0003, 16'h0005, 3'd6);
        repeat (3) tick();
        chk("sub_data", int'(wb_data), 16'hFFFE);
`ifdef ALU_SUB_BORROW_EN
        chk("sub_ccr", int'(ccr), 3'b101);
`else
        chk("sub_ccr", int'(ccr), 3'b100);
`endif

        // Four back-to-back then reset mid-stream
        for (int i = 0; i < 4; i++) send(3'd0, 16'(i * 3), 16'h0010, 3'(i));
        do_reset();
        repeat (5) tick();
        chk("no_stale_beat", int'(wb_valid), 0);

        // Random traffic with random writeback backpressure
        no_bp = 0;
        rand_bp = 1;
        for (int i = 0; i < 400; i++) begin
            logic [2:0] op;
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
            send(op, a, b, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_bp = 0;
        wb_ready = 1'b1;
        repeat (10) tick();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
